// File: rtl/i2s_tdm_tx.sv
// I2S / left-justified TDM master transmitter: a small frame FIFO feeding an
// MSB-first serialiser that drives i2s_sclk, i2s_lrclk and i2s_dout.
module i2s_tdm_tx #(
  parameter int WIDTH      = 16,
  parameter int SLOT       = 32,
  parameter int CHANNELS   = 2,
  parameter int DIV        = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         enable,
  input  logic                         cfg_lj,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         i2s_sclk,
  output logic                         i2s_lrclk,
  output logic                         i2s_dout,
  output logic                         underrun
);

  localparam int FRAME_W = CHANNELS * WIDTH;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(CHANNELS);
  localparam int KW      = (SLOT > 1) ? $clog2(SLOT) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] CH_LAST  = SW'(CHANNELS - 1);
  localparam logic [KW-1:0] BIT_LAST = KW'(SLOT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  // Handshake: a frame transfers on a sys_clk edge where in_valid && in_ready;
  // in_ready depends only on the stored count, never on in_valid or a pop.
  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;

  logic [DW-1:0]      div_cnt;
  logic               started;
  logic [SW-1:0]      slot_idx;
  logic [KW-1:0]      bit_idx;
  logic [FRAME_W-1:0] frame_q;
  logic               lj_q;

  logic               wrap, fall_evt, frame_start, fifo_empty, push, pop;
  logic [SW-1:0]      slot_nxt;
  logic [KW-1:0]      bit_nxt;
  logic [FRAME_W-1:0] src_frame, shifted;
  logic               src_lj, carry_bit, use_sample, fixed_bit, dout_nxt, lrclk_nxt;
  int                 sel_idx;

  assign in_ready   = (count != FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = in_valid && in_ready;
  assign wrap       = enable && (div_cnt == DIV_LAST);
  // The first wrap after enable acts as a falling edge with sclk held low,
  // so bit 0 is on the bus a full half-period before the first rising edge.
  assign fall_evt    = wrap && (!started || i2s_sclk);
  assign frame_start = fall_evt && (!started || (slot_idx == CH_LAST && bit_idx == BIT_LAST));
  assign pop         = frame_start && !fifo_empty;

  always_comb begin
    slot_nxt = slot_idx;
    bit_nxt  = bit_idx;
    if (frame_start) begin
      slot_nxt = '0;
      bit_nxt  = '0;
    end else if (bit_idx == BIT_LAST) begin
      slot_nxt = slot_idx + 1'b1;
      bit_nxt  = '0;
    end else begin
      bit_nxt = bit_idx + 1'b1;
    end
  end

  always_comb begin
    src_frame = frame_q;
    src_lj    = lj_q;
    if (frame_start) begin
      src_frame = fifo_empty ? '0 : mem[rd_ptr];
      src_lj    = cfg_lj;
    end
    // Last channel's LSB of the outgoing I2S frame, delayed into the next frame.
    carry_bit  = (SLOT == WIDTH) && started && !lj_q && frame_q[FRAME_W-WIDTH];
    use_sample = 1'b0;
    fixed_bit  = 1'b0;
    sel_idx    = 0;
    if (src_lj) begin
      if (int'(bit_nxt) < WIDTH) begin
        use_sample = 1'b1;
        sel_idx    = int'(slot_nxt) * WIDTH + WIDTH - 1 - int'(bit_nxt);
      end
    end else if (bit_nxt == '0) begin
      if (slot_nxt == '0) begin
        fixed_bit = carry_bit;
      end else if (SLOT == WIDTH) begin
        use_sample = 1'b1;
        sel_idx    = (int'(slot_nxt) - 1) * WIDTH;
      end
    end else if (int'(bit_nxt) <= WIDTH) begin
      use_sample = 1'b1;
      sel_idx    = int'(slot_nxt) * WIDTH + WIDTH - int'(bit_nxt);
    end
    shifted   = src_frame >> sel_idx;
    dout_nxt  = use_sample ? shifted[0] : fixed_bit;
    lrclk_nxt = (int'(slot_nxt) >= CHANNELS / 2);
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt   <= '0;
      started   <= 1'b0;
      slot_idx  <= '0;
      bit_idx   <= '0;
      frame_q   <= '0;
      lj_q      <= 1'b0;
      i2s_sclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_dout  <= 1'b0;
      underrun  <= 1'b0;
    end else if (!enable) begin
      div_cnt   <= '0;
      started   <= 1'b0;
      slot_idx  <= '0;
      bit_idx   <= '0;
      frame_q   <= '0;
      lj_q      <= 1'b0;
      i2s_sclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_dout  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= frame_start && fifo_empty;
      if (wrap) begin
        div_cnt <= '0;
        if (started) i2s_sclk <= ~i2s_sclk;
        if (fall_evt) begin
          started   <= 1'b1;
          slot_idx  <= slot_nxt;
          bit_idx   <= bit_nxt;
          i2s_lrclk <= lrclk_nxt;
          i2s_dout  <= dout_nxt;
          frame_q   <= src_frame;
          lj_q      <= src_lj;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Bench for i2s_tdm_tx: a stereo 16/16 I2S instance and a 4-channel 24/32
// instance, checked bit-by-bit against a stream model built from the frames.
module tb_i2s_tdm_tx;

  localparam int A_W = 16, A_S = 16, A_CH = 2, A_DIV = 2;
  localparam int B_W = 24, B_S = 32, B_CH = 4, B_DIV = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              en_a, lj_a, valid_a, ready_a, sclk_a, lr_a, dout_a, ur_a;
  logic [A_CH*A_W-1:0] data_a;
  logic              en_b, lj_b, valid_b, ready_b, sclk_b, lr_b, dout_b, ur_b;
  logic [B_CH*B_W-1:0] data_b;

  i2s_tdm_tx #(.WIDTH(A_W), .SLOT(A_S), .CHANNELS(A_CH), .DIV(A_DIV), .FIFO_DEPTH(4)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(en_a), .cfg_lj(lj_a),
    .in_data(data_a), .in_valid(valid_a), .in_ready(ready_a),
    .i2s_sclk(sclk_a), .i2s_lrclk(lr_a), .i2s_dout(dout_a), .underrun(ur_a)
  );

  i2s_tdm_tx #(.WIDTH(B_W), .SLOT(B_S), .CHANNELS(B_CH), .DIV(B_DIV), .FIFO_DEPTH(4)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(en_b), .cfg_lj(lj_b),
    .in_data(data_b), .in_valid(valid_b), .in_ready(ready_b),
    .i2s_sclk(sclk_b), .i2s_lrclk(lr_b), .i2s_dout(dout_b), .underrun(ur_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture of the selected instance, sampled 2 time units after each edge.
  bit   sel_b = 1'b0;
  bit   prev_sclk = 1'b0;
  logic cur_s, cur_l, cur_d, cur_u;
  bit   cap_d[$];
  bit   cap_l[$];
  int   rise_t[$];
  int   ur_t[$];
  int   ur_run = 0;
  int   ur_run_max = 0;
  int   ones_seen = 0;

  always @(posedge clk) begin
    #2;
    cur_s = sel_b ? sclk_b : sclk_a;
    cur_l = sel_b ? lr_b   : lr_a;
    cur_d = sel_b ? dout_b : dout_a;
    cur_u = sel_b ? ur_b   : ur_a;
    if (cur_s && !prev_sclk) begin
      cap_d.push_back(cur_d);
      cap_l.push_back(cur_l);
      rise_t.push_back(cyc);
    end
    prev_sclk = cur_s;
    if (cur_u) begin
      ur_t.push_back(cyc);
      ur_run++;
      if (ur_run > ur_run_max) ur_run_max = ur_run;
    end else begin
      ur_run = 0;
    end
    if (cur_d) ones_seen++;
  end

  // Reference stream: each slot is the sample MSB-first then zero padding
  // (left-justified); I2S is that stream delayed by one bit clock, the
  // delayed-in bit being the last bit of the previous frame of this run.
  bit exp_d[$];
  bit exp_l[$];
  bit carry = 1'b0;

  task automatic model_frame(input logic [127:0] frame, input int w, input int s,
                             input int ch, input bit lj);
    bit lb[$];
    bit lr[$];
    logic [127:0] t;
    for (int c = 0; c < ch; c++) begin
      for (int k = 0; k < s; k++) begin
        if (k < w) begin
          t = frame >> (c * w + w - 1 - k);
          lb.push_back(t[0]);
        end else begin
          lb.push_back(1'b0);
        end
        lr.push_back(c >= ch / 2);
      end
    end
    for (int i = 0; i < lb.size(); i++) begin
      exp_d.push_back(lj ? lb[i] : ((i == 0) ? carry : lb[i-1]));
      exp_l.push_back(lr[i]);
    end
    carry = lb[lb.size()-1];
  endtask

  task automatic model_reset();
    exp_d.delete();
    exp_l.delete();
    carry = 1'b0;
  endtask

  task automatic clear_cap();
    cap_d.delete();
    cap_l.delete();
    rise_t.delete();
    ur_t.delete();
    ur_run_max = 0;
    ones_seen = 0;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_bits(input int n, input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cap_d.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, " bit timeout"}, 128'(cap_d.size()), 128'(n));
  endtask

  task automatic cmp_frames(input string tag, input int nframes, input int fbits);
    logic [127:0] gd, ed, gl, el;
    int idx;
    for (int f = 0; f < nframes; f++) begin
      gd = '0; ed = '0; gl = '0; el = '0;
      for (int i = 0; i < fbits; i++) begin
        idx = f * fbits + i;
        gd = {gd[126:0], (idx < cap_d.size()) ? logic'(cap_d[idx]) : 1'bx};
        gl = {gl[126:0], (idx < cap_l.size()) ? logic'(cap_l[idx]) : 1'bx};
        ed = {ed[126:0], (idx < exp_d.size()) ? logic'(exp_d[idx]) : 1'b0};
        el = {el[126:0], (idx < exp_l.size()) ? logic'(exp_l[idx]) : 1'b0};
      end
      chk($sformatf("%s dout frame %0d", tag, f), gd, ed);
      chk($sformatf("%s lrclk frame %0d", tag, f), gl, el);
    end
  endtask

  task automatic push_a(input logic [A_CH*A_W-1:0] d);
    bit ok = 1'b0;
    valid_a = 1'b1;
    data_a = d;
    for (int i = 0; i < 2000; i++) begin
      if (ready_a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("push_a ready timeout", 128'(ready_a), 128'(1));
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [B_CH*B_W-1:0] d);
    bit ok = 1'b0;
    valid_b = 1'b1;
    data_b = d;
    for (int i = 0; i < 2000; i++) begin
      if (ready_b) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("push_b ready timeout", 128'(ready_b), 128'(1));
    @(negedge clk);
    valid_b = 1'b0;
  endtask

  logic [A_CH*A_W-1:0] fa[5];
  logic [B_CH*B_W-1:0] fb[3];
  logic [31:0]         sw, lw;
  int                  bad;
  bit                  ok;

  initial begin
    en_a = 0; lj_a = 0; valid_a = 0; data_a = '0;
    en_b = 0; lj_b = 0; valid_b = 0; data_b = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs a", {sclk_a, lr_a, dout_a, ur_a, ready_a}, 5'b00001);
    chk("reset outputs b", {sclk_b, lr_b, dout_b, ur_b, ready_b}, 5'b00001);
    rst_n = 1'b1;
    @(negedge clk);

    // Stereo I2S with the reference frame first, then random frames.
    fa[0] = {16'h0F5A, 16'hA5F0};
    for (int i = 1; i < 4; i++) fa[i] = $urandom;
    for (int i = 0; i < 4; i++) push_a(fa[i]);
    model_reset();
    for (int i = 0; i < 4; i++) model_frame(128'(fa[i]), A_W, A_S, A_CH, 1'b0);
    clear_cap();
    en_a = 1'b1;
    wait_bits(128, 1000, "t1");
    en_a = 1'b0;
    cmp_frames("t1", 4, A_CH * A_S);
    if (rise_t.size() >= 2) chk("t1 sclk period", 128'(rise_t[1] - rise_t[0]), 128'(2 * A_DIV));
    else chk("t1 sclk period rises", 128'(rise_t.size()), 128'(2));
    chk("t1 no underrun", 128'(ur_t.size()), 128'(0));
    repeat (3) @(negedge clk);

    // Empty FIFO: zero data and one underrun pulse per frame.
    clear_cap();
    en_a = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ur_t.size() >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    en_a = 1'b0;
    if (ok) begin
      chk("t2 underrun spacing 1", 128'(ur_t[1] - ur_t[0]), 128'(2 * A_DIV * A_CH * A_S));
      chk("t2 underrun spacing 2", 128'(ur_t[2] - ur_t[1]), 128'(2 * A_DIV * A_CH * A_S));
    end else begin
      chk("t2 underrun timeout", 128'(ur_t.size()), 128'(3));
    end
    chk("t2 underrun width", 128'(ur_run_max), 128'(1));
    chk("t2 dout idle zero", 128'(ones_seen), 128'(0));
    repeat (3) @(negedge clk);

    // Back-to-back pushes while idle: fifth waits for the first pop.
    for (int i = 0; i < 5; i++) fa[i] = $urandom;
    for (int i = 0; i < 5; i++) begin
      data_a = fa[i];
      valid_a = 1'b1;
      chk($sformatf("t3 in_ready before push %0d", i), 128'(ready_a), 128'(i < 4));
      if (i < 4) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("t3 in_ready held low when full", 128'(ready_a), 128'(0));
    model_reset();
    for (int i = 0; i < 5; i++) model_frame(128'(fa[i]), A_W, A_S, A_CH, 1'b0);
    clear_cap();
    en_a = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ready_a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t3 fifth frame accepted", 128'(ok), 128'(1));
    @(negedge clk);
    valid_a = 1'b0;
    wait_bits(160, 1500, "t3");
    en_a = 1'b0;
    cmp_frames("t3", 5, A_CH * A_S);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-frame, then an underrun frame of zeros.
    push_a($urandom);
    push_a($urandom);
    clear_cap();
    en_a = 1'b1;
    wait_bits(20, 400, "t5 pre");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("t5 async reset outputs", {sclk_a, lr_a, dout_a, ur_a, ready_a}, 5'b00001);
    @(negedge clk);
    chk("t5 reset held outputs", {sclk_a, lr_a, dout_a, ready_a}, 4'b0001);
    clear_cap();
    model_reset();
    model_frame(128'(0), A_W, A_S, A_CH, 1'b0);
    rst_n = 1'b1;
    wait_bits(32, 400, "t5");
    en_a = 1'b0;
    cmp_frames("t5", 1, A_CH * A_S);
    chk("t5 underrun after reset", 128'(ur_t.size()), 128'(1));
    repeat (3) @(negedge clk);

    // Drop enable mid-slot: bus idles, resumes at frame start with next frame.
    for (int i = 0; i < 4; i++) fa[i] = $urandom;
    for (int i = 0; i < 4; i++) push_a(fa[i]);
    clear_cap();
    en_a = 1'b1;
    wait_bits(40, 600, "t6 pre");
    en_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sclk_a || lr_a || dout_a || ur_a) bad++;
    end
    chk("t6 idle bus while disabled", 128'(bad), 128'(0));
    chk("t6 fifo kept not full", 128'(ready_a), 128'(1));
    model_reset();
    model_frame(128'(fa[2]), A_W, A_S, A_CH, 1'b0);
    model_frame(128'(fa[3]), A_W, A_S, A_CH, 1'b0);
    clear_cap();
    en_a = 1'b1;
    wait_bits(64, 600, "t6");
    en_a = 1'b0;
    cmp_frames("t6", 2, A_CH * A_S);
    chk("t6 no underrun on resume", 128'(ur_t.size()), 128'(0));
    repeat (3) @(negedge clk);

    // Four-channel 24/32 left-justified, switching to I2S mid-frame 1.
    sel_b = 1'b1;
    lj_b = 1'b1;
    fb[0] = {4{24'h800001}};
    fb[1] = {$urandom, $urandom, $urandom};
    fb[2] = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) push_b(fb[i]);
    model_reset();
    model_frame(128'(fb[0]), B_W, B_S, B_CH, 1'b1);
    model_frame(128'(fb[1]), B_W, B_S, B_CH, 1'b1);
    model_frame(128'(fb[2]), B_W, B_S, B_CH, 1'b0);
    clear_cap();
    en_b = 1'b1;
    wait_bits(140, 1500, "t4 pre");
    lj_b = 1'b0;
    wait_bits(384, 3000, "t4");
    en_b = 1'b0;
    cmp_frames("t4", 3, B_CH * B_S);
    for (int s = 0; s < B_CH; s++) begin
      sw = '0;
      lw = '0;
      for (int i = 0; i < B_S; i++) begin
        sw = {sw[30:0], (s * B_S + i < cap_d.size()) ? logic'(cap_d[s * B_S + i]) : 1'bx};
        lw = {lw[30:0], (s * B_S + i < cap_l.size()) ? logic'(cap_l[s * B_S + i]) : 1'bx};
      end
      chk($sformatf("t4 slot %0d pattern", s), 128'(sw), 128'(32'h8000_0100));
      chk($sformatf("t4 slot %0d lrclk", s), 128'(lw), (s >= B_CH / 2) ? 128'(32'hFFFF_FFFF) : 128'(0));
    end
    chk("t4 no underrun", 128'(ur_t.size()), 128'(0));
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
